// File: rtl/aemb_dwb_ram_if.sv
// Wishbone data-bus bundle between the AEMB2 core (master) and the
// on-chip RAM/debug responder (slave).
interface aemb_dwb_ram_if #(
  parameter int AW = 18
);
  logic [AW-1:2] dwb_adr_i;
  logic [31:0]   dwb_dat_i;
  logic [3:0]    dwb_sel_i;
  logic          dwb_stb_i;
  logic          dwb_cyc_i;
  logic          dwb_wre_i;
  logic [31:0]   dwb_dat_o;
  logic          dwb_ack_o;

  modport master (
    output dwb_adr_i, dwb_dat_i, dwb_sel_i, dwb_stb_i, dwb_cyc_i, dwb_wre_i,
    input  dwb_dat_o, dwb_ack_o
  );

  modport slave (
    input  dwb_adr_i, dwb_dat_i, dwb_sel_i, dwb_stb_i, dwb_cyc_i, dwb_wre_i,
    output dwb_dat_o, dwb_ack_o
  );
endinterface

// File: rtl/aemb_dwb_ram.sv
// Data-bus responder for AEMB2: byte-lane RAM, programmable wait states and
// memory-mapped console / hex / interrupt-toggle debug peripherals.
module aemb_dwb_ram #(
  parameter int AW   = 18,
  parameter int MW   = 10,
  parameter int WAIT = 0
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_i,
  aemb_dwb_ram_if.slave   dwb,
  output logic [7:0]      con_dat_o,
  output logic            con_stb_o,
  output logic [31:0]     hex_dat_o,
  output logic            hex_stb_o,
  output logic            sys_int_o,
  output logic            err_o,
  output logic [AW-1:2]   err_adr_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAITING = 2'b01,
    ACK     = 2'b10
  } state_t;

  localparam logic [3:0] WAIT_C  = 4'(WAIT);
  localparam logic [5:0] OFF_CON = 6'h30;
  localparam logic [5:0] OFF_HEX = 6'h34;
  localparam logic [5:0] OFF_INT = 6'h38;

  // Only contiguous aligned lane groups are legal byte selects.
  function automatic logic sel_valid_f(input logic [3:0] sel);
    case (sel)
      4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF: sel_valid_f = 1'b1;
      default:                                 sel_valid_f = 1'b0;
    endcase
  endfunction

  state_t          state_r, state_nxt_s;
  logic [3:0]      cnt_r, cnt_nxt_s;
  logic            commit_s;
  logic            ack_r;
  logic [31:0]     dat_r;
  logic [7:0]      con_dat_r;
  logic            con_stb_r;
  logic [31:0]     hex_dat_r;
  logic            hex_stb_r;
  logic            sys_int_r;
  logic            err_r;
  logic [AW-1:2]   err_adr_r;
  logic [31:0]     mem_r [0:(1<<MW)-1];

  logic            req_s, io_s, sel_ok_s, wr_ok_s;
  logic [5:0]      off_s;
  logic [MW-1:0]   idx_s;
  logic [31:0]     rd_data_s;

  assign req_s    = dwb.dwb_stb_i & dwb.dwb_cyc_i & ~ack_r;
  assign io_s     = &dwb.dwb_adr_i[AW-1:8];
  assign off_s    = dwb.dwb_adr_i[7:2];
  assign idx_s    = dwb.dwb_adr_i[MW+1:2];
  assign sel_ok_s = sel_valid_f(dwb.dwb_sel_i);
  assign wr_ok_s  = commit_s & dwb.dwb_wre_i & sel_ok_s;

  // Next-state logic; commit_s marks the edge that raises ack.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    commit_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (!req_s) begin
          state_nxt_s = IDLE;
        end else if (WAIT_C == 4'd0) begin
          state_nxt_s = ACK;
          commit_s    = 1'b1;
        end else begin
          state_nxt_s = WAITING;
          cnt_nxt_s   = WAIT_C - 4'd1;
        end
      end
      WAITING: begin
        if (!(dwb.dwb_stb_i && dwb.dwb_cyc_i)) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end else if (cnt_r == 4'd0) begin
          state_nxt_s = ACK;
          commit_s    = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r - 4'd1;
        end
      end
      ACK: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Read-data selection; an illegal select always reads back zero.
  always_comb begin
    rd_data_s = 32'h0;
    if (!sel_ok_s) begin
      rd_data_s = 32'h0;
    end else if (io_s) begin
      case (off_s)
        OFF_HEX: rd_data_s = hex_dat_r;
        OFF_INT: rd_data_s = {31'h0, sys_int_r};
        default: rd_data_s = 32'h0;
      endcase
    end else begin
      rd_data_s = mem_r[idx_s];
    end
  end

  // Control state and bus response registers.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      ack_r   <= 1'b0;
      dat_r   <= 32'h0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ack_r   <= (state_nxt_s == ACK);
      dat_r   <= (commit_s && !dwb.dwb_wre_i) ? rd_data_s : 32'h0;
    end
  end

  // Debug peripherals and sticky select-error capture.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      con_dat_r <= 8'h0;
      con_stb_r <= 1'b0;
      hex_dat_r <= 32'h0;
      hex_stb_r <= 1'b0;
      sys_int_r <= 1'b1;
      err_r     <= 1'b0;
      err_adr_r <= {(AW-2){1'b0}};
    end else begin
      con_stb_r <= wr_ok_s & io_s & (off_s == OFF_CON);
      hex_stb_r <= wr_ok_s & io_s & (off_s == OFF_HEX);
      if (wr_ok_s && io_s && (off_s == OFF_CON)) con_dat_r <= dwb.dwb_dat_i[31:24];
      if (wr_ok_s && io_s && (off_s == OFF_HEX)) hex_dat_r <= dwb.dwb_dat_i;
      if (wr_ok_s && io_s && (off_s == OFF_INT)) sys_int_r <= ~sys_int_r;
      if (commit_s && !sel_ok_s) begin
        err_r <= 1'b1;
        if (!err_r) err_adr_r <= dwb.dwb_adr_i;
      end
    end
  end

  // RAM array with per-lane write enables; contents are never reset.
  always_ff @(posedge sys_clk_i) begin
    if (wr_ok_s && !io_s) begin
      for (int i = 0; i < 4; i++) begin
        if (dwb.dwb_sel_i[i]) mem_r[idx_s][8*i +: 8] <= dwb.dwb_dat_i[8*i +: 8];
      end
    end
  end

  assign dwb.dwb_ack_o = ack_r;
  assign dwb.dwb_dat_o = dat_r;
  assign con_dat_o     = con_dat_r;
  assign con_stb_o     = con_stb_r;
  assign hex_dat_o     = hex_dat_r;
  assign hex_stb_o     = hex_stb_r;
  assign sys_int_o     = sys_int_r;
  assign err_o         = err_r;
  assign err_adr_o     = err_adr_r;

endmodule
